// File: rtl/muldiv_if.sv
// Issue-stage request and HI/LO access bundle for the multiply/divide unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_if;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hi_read;
   logic        lo_read;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, src_a, src_b,
      output hi_read, lo_read, hi_we, lo_we,
      output wdata, flush,
      input  stall, busy, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, src_a, src_b,
      input  hi_read, lo_read, hi_we, lo_we,
      input  wdata, flush,
      output stall, busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit and HI/LO register owner.
// Fixed-latency multiply, 32-step restoring divide with sign fix-up.
module muldiv_unit #(
   parameter int MUL_LAT = 3
) (
   input logic     clk,
   input logic     reset,
   muldiv_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } state_t;

   localparam logic [3:0] OP_MULT  = 4'b1011;
   localparam logic [3:0] OP_MULTU = 4'b1100;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1110;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        sgn_q, sgn_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        legal_op;
   logic        is_mul;
   logic        op_sgn;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] product;
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        borrow;
   logic        neg_quo;
   logic        neg_rem;

   assign legal_op = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU) ||
                     (bus.req_op == OP_DIV)  || (bus.req_op == OP_DIVU);
   assign is_mul   = (bus.req_op == OP_MULT) || (bus.req_op == OP_MULTU);
   assign op_sgn   = (bus.req_op == OP_MULT) || (bus.req_op == OP_DIV);

   // Low 64 bits of the product of sign-extended operands give both flavours.
   assign mul_a   = {{32{sgn_q & a_q[31]}}, a_q};
   assign mul_b   = {{32{sgn_q & b_q[31]}}, b_q};
   assign product = mul_a * mul_b;

   // quo_q starts as the dividend and shifts quotient bits in from the LSB.
   assign rem_sh  = {rem_q, quo_q[31]};
   assign diff    = rem_sh - {1'b0, dvs_q};
   assign borrow  = diff[32];
   assign neg_quo = sgn_q & (a_q[31] ^ b_q[31]);
   assign neg_rem = sgn_q & a_q[31];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!bus.flush) begin
               if (bus.req_valid && legal_op) begin
                  a_d   = bus.src_a;
                  b_d   = bus.src_b;
                  sgn_d = op_sgn;
                  if (is_mul) begin
                     state_d = S_MUL;
                     cnt_d   = 6'd1;
                  end else begin
                     state_d = S_DIV;
                     cnt_d   = 6'd0;
                     rem_d   = 32'd0;
                     quo_d   = (op_sgn && bus.src_a[31]) ? -bus.src_a : bus.src_a;
                     dvs_d   = (op_sgn && bus.src_b[31]) ? -bus.src_b : bus.src_b;
                  end
               end else begin
                  if (bus.hi_we) hi_d = bus.wdata;
                  if (bus.lo_we) lo_d = bus.wdata;
               end
            end
         end
         S_MUL: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else if (cnt_q == 6'(MUL_LAT)) begin
               hi_d    = product[63:32];
               lo_d    = product[31:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         S_DIV: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               rem_d = borrow ? rem_sh[31:0] : diff[31:0];
               quo_d = {quo_q[30:0], ~borrow};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               // Divide by zero returns the raw dividend with no sign fix-up.
               if (b_q == 32'd0) begin
                  hi_d = a_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  hi_d = neg_rem ? -rem_q : rem_q;
                  lo_d = neg_quo ? -quo_q : quo_q;
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         sgn_q   <= 1'b0;
         quo_q   <= 32'd0;
         rem_q   <= 32'd0;
         dvs_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy  = (state_q != S_IDLE);
   assign bus.stall = bus.busy & (bus.req_valid | bus.hi_read | bus.lo_read |
                                  bus.hi_we | bus.lo_we);
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule
